// File: rtl/pipe_ctrl_pkg.sv
// Shared core package: ALU/PC modes, pipe FSM states, forwarding selects.
// Used by pipe_ctrl (optional PIPE_CTRL_PERF_EN counters) and fwd_unit.
package pipe_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_SEQ,
    PC_BRANCH,
    PC_JAL,
    PC_JALR
  } pc_mode_t;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    DRAIN,
    HALT
  } pipe_state_t;

  localparam int FWD_SEL_BITS = 2;

  localparam logic [FWD_SEL_BITS-1:0] FWD_REG = 2'd0;
  localparam logic [FWD_SEL_BITS-1:0] FWD_MEM = 2'd1;
  localparam logic [FWD_SEL_BITS-1:0] FWD_WB  = 2'd2;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding compare for one EX source register.
// MEM result beats WB result; x0 is never forwarded.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0]              rs_i,
  input  logic                    mem_valid_i,
  input  logic                    mem_wr_i,
  input  logic [4:0]              mem_rd_i,
  input  logic                    wb_valid_i,
  input  logic                    wb_wr_i,
  input  logic [4:0]              wb_rd_i,
  output logic [FWD_SEL_BITS-1:0] sel_o
);

  logic rs_nz;
  logic mem_hit;
  logic wb_hit;

  assign rs_nz   = (rs_i != 5'd0);
  assign mem_hit = mem_valid_i & mem_wr_i
                 & (mem_rd_i == rs_i) & rs_nz;
  assign wb_hit  = wb_valid_i & wb_wr_i
                 & (wb_rd_i == rs_i) & rs_nz;

  always_comb begin
    sel_o = FWD_REG;
    if (mem_hit) begin
      sel_o = FWD_MEM;
    end else if (wb_hit) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard/sequencing controller: stalls, flushes, forwarding, halt FSM.
// PIPE_CTRL_PERF_EN adds cycle/instret/stall performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_BITS     = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_valid,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       ex_redirect,
  input  logic       ex_exception,
  input  logic       mem_valid,
  input  logic       mem_reg_write,
  input  logic [4:0] mem_rd,
  input  logic       mem_access,
  input  logic       dmem_ready,
  input  logic       wb_valid,
  input  logic       wb_reg_write,
  input  logic [4:0] wb_rd,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_ex,
  output logic       stall_mem,
  output logic       flush_id,
  output logic       flush_ex,
  output logic       flush_wb,
  output logic [FWD_SEL_BITS-1:0] fwd_a_sel,
  output logic [FWD_SEL_BITS-1:0] fwd_b_sel,
  output logic       halted
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_BITS-1:0] cycle_cnt,
  output logic [CNT_BITS-1:0] instret_cnt,
  output logic [CNT_BITS-1:0] stall_cnt
`endif
);

  localparam int CW =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] DRAIN_INIT =
    CW'(DRAIN_CYCLES - 1);

  if (CNT_BITS < 1 || DRAIN_CYCLES < 1) begin : g_bad_cfg
    $error("pipe_ctrl: bad parameters");
  end

  pipe_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    ex_rs1_q, ex_rs2_q;

  logic mem_wait;
  logic exc;
  logic redir;
  logic ld_use;

  assign mem_wait = mem_valid & mem_access & ~dmem_ready;
  assign exc      = ex_valid & ex_exception;
  assign redir    = ex_valid & ex_redirect;
  assign ld_use   = id_valid & ex_valid & ex_mem_read
                  & (ex_rd != 5'd0)
                  & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_wb  = 1'b0;
    halted    = 1'b0;
    unique case (state_q)
      RUN, MEM_WAIT: begin
        if (mem_wait) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          stall_mem = 1'b1;
          flush_wb  = 1'b1;
          state_d   = MEM_WAIT;
        end else if (exc) begin
          stall_if = 1'b1;
          flush_id = 1'b1;
          flush_ex = 1'b1;
          state_d  = DRAIN;
          cnt_d    = DRAIN_INIT;
        end else begin
          state_d = RUN;
          // wrong-path instruction in ID: no point stalling it
          if (redir) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
          end else if (ld_use) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
          end
        end
      end
      DRAIN: begin
        stall_if = 1'b1;
        flush_id = 1'b1;
        flush_ex = 1'b1;
        if (mem_wait) begin
          stall_mem = 1'b1;
          flush_wb  = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = HALT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HALT: begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
        halted    = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // EX-stage copies of the ID sources; a bubble reads x0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_rs1_q <= 5'd0;
      ex_rs2_q <= 5'd0;
    end else if (flush_ex) begin
      ex_rs1_q <= 5'd0;
      ex_rs2_q <= 5'd0;
    end else if (!stall_ex) begin
      ex_rs1_q <= id_rs1;
      ex_rs2_q <= id_rs2;
    end
  end

  fwd_unit u_fwd_a (
    .rs_i        (ex_rs1_q),
    .mem_valid_i (mem_valid),
    .mem_wr_i    (mem_reg_write),
    .mem_rd_i    (mem_rd),
    .wb_valid_i  (wb_valid),
    .wb_wr_i     (wb_reg_write),
    .wb_rd_i     (wb_rd),
    .sel_o       (fwd_a_sel)
  );

  fwd_unit u_fwd_b (
    .rs_i        (ex_rs2_q),
    .mem_valid_i (mem_valid),
    .mem_wr_i    (mem_reg_write),
    .mem_rd_i    (mem_rd),
    .wb_valid_i  (wb_valid),
    .wb_wr_i     (wb_reg_write),
    .wb_rd_i     (wb_rd),
    .sel_o       (fwd_b_sel)
  );

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_BITS-1:0] cyc_q, cyc_d;
  logic [CNT_BITS-1:0] ret_q, ret_d;
  logic [CNT_BITS-1:0] stl_q, stl_d;
  logic                live;

  assign live = (state_q != HALT);

  always_comb begin
    cyc_d = cyc_q;
    ret_d = ret_q;
    stl_d = stl_q;
    if (live) cyc_d = cyc_q + 1'b1;
    if (wb_valid & ~flush_wb) ret_d = ret_q + 1'b1;
    if (live & stall_id) stl_d = stl_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ret_q <= '0;
      stl_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
      stl_q <= stl_d;
    end
  end

  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ret_q;
  assign stall_cnt   = stl_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazards, forwarding, wait, drain, halt.
// Control strobes checked as {sif,sid,sex,smem,fid,fex,fwb,halt}.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2;
  logic       ex_valid, ex_reg_write, ex_mem_read;
  logic [4:0] ex_rd;
  logic       ex_redirect, ex_exception;
  logic       mem_valid, mem_reg_write;
  logic [4:0] mem_rd;
  logic       mem_access, dmem_ready;
  logic       wb_valid, wb_reg_write;
  logic [4:0] wb_rd;
  logic       stall_if, stall_id, stall_ex, stall_mem;
  logic       flush_id, flush_ex, flush_wb;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       halted;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt, stall_cnt;
  logic [31:0] snap;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .ex_valid      (ex_valid),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_rd         (ex_rd),
    .ex_redirect   (ex_redirect),
    .ex_exception  (ex_exception),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_access    (mem_access),
    .dmem_ready    (dmem_ready),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .stall_if      (stall_if),
    .stall_id      (stall_id),
    .stall_ex      (stall_ex),
    .stall_mem     (stall_mem),
    .flush_id      (flush_id),
    .flush_ex      (flush_ex),
    .flush_wb      (flush_wb),
    .fwd_a_sel     (fwd_a_sel),
    .fwd_b_sel     (fwd_b_sel),
    .halted        (halted)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .cycle_cnt     (cycle_cnt),
    .instret_cnt   (instret_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  function automatic logic [7:0] ctl();
    return {stall_if, stall_id, stall_ex, stall_mem,
            flush_id, flush_ex, flush_wb, halted};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, got, exp);
    end
  endtask

  task automatic quiet();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0;
    ex_valid = 0; ex_reg_write = 0; ex_mem_read = 0;
    ex_rd = 0; ex_redirect = 0; ex_exception = 0;
    mem_valid = 0; mem_reg_write = 0; mem_rd = 0;
    mem_access = 0; dmem_ready = 1;
    wb_valid = 0; wb_reg_write = 0; wb_rd = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0;
    quiet();
    id_rs1 = 7; id_rs2 = 7;
    nxt();
    // reset state: EX sources cleared despite a MEM x7 producer
    rst_n = 1;
    mem_valid = 1; mem_reg_write = 1; mem_rd = 7;
    #2;
    chk("rst_ctl", ctl(), 8'h00);
    chk("rst_fwd_a", fwd_a_sel, 0);
    chk("rst_fwd_b", fwd_b_sel, 0);

    nxt();
    wb_valid = 1; wb_reg_write = 1; wb_rd = 7;
    #2;
    chk("fwd_mem_pri_a", fwd_a_sel, 1);
    chk("fwd_mem_pri_b", fwd_b_sel, 1);

    nxt();
    mem_valid = 0;
    id_rs1 = 0; id_rs2 = 0;
    #2;
    chk("fwd_wb_a", fwd_a_sel, 2);

    nxt();
    mem_valid = 1; mem_rd = 0; wb_rd = 0;
    #2;
    chk("fwd_x0_a", fwd_a_sel, 0);
    chk("fwd_x0_b", fwd_b_sel, 0);

    // load-use: lw x5 in EX, add x6,x5,x1 in ID
    nxt();
    quiet();
    ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1;
    ex_rd = 5;
    id_valid = 1; id_rs1 = 5; id_rs2 = 1;
    #2;
    chk("lu", ctl(), 8'hC4);

    nxt();
    ex_valid = 0; ex_mem_read = 0; ex_rd = 0;
    mem_valid = 1; mem_reg_write = 1; mem_rd = 5;
    #2;
    chk("lu_once", ctl(), 8'h00);
    chk("lu_bubble_fwd", fwd_a_sel, 0);

    nxt();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0;
    ex_valid = 1; ex_rd = 6;
    mem_valid = 0; mem_reg_write = 0; mem_rd = 0;
    wb_valid = 1; wb_reg_write = 1; wb_rd = 5;
    #2;
    chk("lu_fwd_a", fwd_a_sel, 2);
    chk("lu_fwd_b", fwd_b_sel, 0);
    chk("lu_ctl", ctl(), 8'h00);

    nxt();
    quiet();
    ex_valid = 1; ex_mem_read = 1; ex_rd = 0;
    id_valid = 1;
    #2;
    chk("lu_x0", ctl(), 8'h00);

    // redirect with load-use on rs2: flushes only
    nxt();
    ex_rd = 5; ex_redirect = 1; id_rs2 = 5;
    #2;
    chk("redir_lu", ctl(), 8'h0C);

    nxt();
    quiet();
    #2;
    chk("redir_once", ctl(), 8'h00);

    // store waits 3 cycles; a redirect in EX waits too
    nxt();
    mem_valid = 1; mem_access = 1; dmem_ready = 0;
    ex_valid = 1; ex_redirect = 1;
    #2;
    chk("mw1", ctl(), 8'hF2);
`ifdef PIPE_CTRL_PERF_EN
    snap = stall_cnt;
`endif
    nxt();
    #2;
    chk("mw2", ctl(), 8'hF2);
    nxt();
    #2;
    chk("mw3", ctl(), 8'hF2);
    nxt();
    dmem_ready = 1;
    #2;
    chk("mw_release", ctl(), 8'h0C);
`ifdef PIPE_CTRL_PERF_EN
    chk("stall_cnt", stall_cnt - snap, 3);
`endif
    nxt();
    quiet();
    #2;
    chk("mw_run", ctl(), 8'h00);

    // exception held during a wait, acted on at release
    nxt();
    mem_valid = 1; mem_access = 1; dmem_ready = 0;
    ex_valid = 1; ex_exception = 1;
    #2;
    chk("mw_exc", ctl(), 8'hF2);
    nxt();
    dmem_ready = 1;
    #2;
    chk("exc", ctl(), 8'h8C);

    nxt();
    quiet();
    mem_valid = 1; mem_access = 1; dmem_ready = 0;
    #2;
    chk("drain_mw", ctl(), 8'h9E);
    nxt();
    quiet();
    #2;
    chk("drain1", ctl(), 8'h8C);
    nxt();
    #2;
    chk("drain2", ctl(), 8'h8C);
    nxt();
    #2;
    chk("halt", ctl(), 8'hF1);
    nxt();
    ex_valid = 1; ex_redirect = 1;
    #2;
    chk("halt_hold", ctl(), 8'hF1);

    nxt();
    quiet();
    rst_n = 0;
    nxt();
    rst_n = 1;
    #2;
    chk("post_rst", ctl(), 8'h00);
    chk("post_rst_fwd", {fwd_a_sel, fwd_b_sel}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
